// File: rtl/aes_engine_scheduler.sv
// aes_engine_scheduler: round-robin sharing of one iterative AES-128 engine with tagged responses
module aes_engine_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int ENG_LATENCY = 41,
   parameter int IDW         = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*128-1:0] req_text,
   input  logic [NUM_REQ*128-1:0] req_key,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [127:0]           rsp_data,
   output logic [IDW-1:0]         rsp_id,
   output logic                   busy,
   output logic [15:0]            ops_done,
   output logic                   eng_rst,
   output logic                   eng_start,
   output logic [127:0]           eng_in,
   output logic [127:0]           eng_key,
   input  logic [127:0]           eng_out
);
   localparam int CW = $clog2(ENG_LATENCY + 1);
   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, RESP} state_t;
   state_t state, state_nxt;
   logic [IDW-1:0] rr_ptr, win, idx;
   logic any;
   logic [CW-1:0] cnt;
   // winner: first valid requester after the last grant, scanned downward so the nearest one wins
   always_comb begin
      win = '0;
      idx = '0;
      any = 1'b0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
         if (req_valid[idx]) begin
            win = idx;
            any = 1'b1;
         end
      end
   end
   assign req_ready = (state == IDLE && any) ? (NUM_REQ'(1) << win) : '0;
   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end
   // job sequencing: grant, engine reset, start pulse, latency wait, response hold
   always_comb begin
      state_nxt = state;
      state_nxt = state == IDLE  ? (any ? LOAD : IDLE) :
                  state == LOAD  ? START :
                  state == START ? WAIT :
                  state == WAIT  ? (cnt == '0 ? RESP : WAIT) :
                  state == RESP  ? (rsp_ready ? IDLE : RESP) : IDLE;
   end
   // datapath: operand latch, engine controls, latency counter, response and job count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eng_rst   <= 1'b1;
         eng_start <= 1'b0;
         eng_in    <= '0;
         eng_key   <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= '0;
         busy      <= 1'b0;
         ops_done  <= '0;
         rr_ptr    <= IDW'(NUM_REQ - 1);
         cnt       <= '0;
      end else begin
         busy <= state_nxt != IDLE;
         case (state)
            IDLE: begin
               eng_rst <= any;
               if (any) begin
                  eng_in  <= req_text[128*win +: 128];
                  eng_key <= req_key[128*win +: 128];
                  rsp_id  <= win;
                  rr_ptr  <= win;
               end
            end
            LOAD: begin
               eng_rst   <= 1'b0;
               eng_start <= 1'b1;
            end
            START: begin
               eng_start <= 1'b0;
               cnt       <= CW'(ENG_LATENCY - 1);
            end
            WAIT: begin
               if (cnt == '0) begin
                  rsp_data  <= eng_out;
                  rsp_valid <= 1'b1;
               end else cnt <= cnt - 1'b1;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  ops_done  <= ops_done + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_engine_scheduler.sv
// tb_aes_engine_scheduler: directed bench with a cycle-level job model and a stand-in AES engine
module tb_aes_engine_scheduler;
   localparam int N = 4;
   localparam int LAT = 41;
   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] T1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] T2 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] K3 = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] T3 = 128'hdeadbeefcafef00d0badc0de12345678;

   logic clk = 0, rst = 1, rsp_ready = 1;
   logic [N-1:0] req_valid = '0, req_ready;
   logic [N*128-1:0] req_text = '0, req_key = '0;
   logic rsp_valid, busy, eng_rst, eng_start;
   logic [127:0] rsp_data, eng_in, eng_key, eng_out;
   logic [1:0] rsp_id;
   logic [15:0] ops_done;
   int cyc = 0, n_chk = 0, n_fail = 0, n_st = 0, n_rs = 0;
   int grants[$];

   aes_engine_scheduler #(.NUM_REQ(N), .ENG_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_text(req_text), .req_key(req_key), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy), .ops_done(ops_done),
      .eng_rst(eng_rst), .eng_start(eng_start), .eng_in(eng_in), .eng_key(eng_key), .eng_out(eng_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // stand-in cipher: the two known AES vectors, a keyed scramble for anything else
   function automatic logic [127:0] aes_ref(input logic [127:0] t, input logic [127:0] k);
      if (k == K1 && t == T1) return C1;
      if (k == K2 && t == T2) return C2;
      return t ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   endfunction

   // engine: captures operands under eng_rst, result valid only LAT cycles after the start cycle
   logic [127:0] e_in = '0, e_key = '0;
   int e_cnt = 0;
   always @(posedge clk) begin
      if (eng_rst) begin
         e_in  <= eng_in;
         e_key <= eng_key;
      end
      if (eng_start) e_cnt <= 1;
      else if (e_cnt != 0) e_cnt <= e_cnt + 1;
   end
   assign eng_out = (e_cnt == LAT) ? aes_ref(e_in, e_key) : ~aes_ref(e_in, e_key);

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // job model: one job at a time, timed in cycles from its accept
   logic m_act = 0;
   int m_age = 0, m_ops = 0, m_rr = N - 1, m_own = 0, w;
   logic [127:0] m_text, m_key;
   logic [N-1:0] exp_rdy;
   always @(negedge clk) begin
      if (rst) begin
         check("rst_eng_rst", eng_rst, 1);
         check("rst_eng_start", eng_start, 0);
         check("rst_rsp_valid", rsp_valid, 0);
         check("rst_rsp_data", rsp_data, 0);
         check("rst_busy", busy, 0);
         check("rst_ops_done", ops_done, 0);
         m_act = 0;
         m_ops = 0;
         m_rr = N - 1;
      end else begin
         w = -1;
         for (int k = 1; k <= N; k++) if (w < 0 && req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
         if (m_act) m_age++;
         exp_rdy = (!m_act && w >= 0) ? (N'(1) << w) : '0;
         check("req_ready", req_ready, exp_rdy);
         check("ready_onehot", $onehot0(req_ready), 1);
         check("busy", busy, m_act);
         check("ops_done", ops_done, m_ops[15:0]);
         check("eng_start", eng_start, m_act && m_age == 2);
         check("rsp_valid", rsp_valid, m_act && m_age >= LAT + 3);
         if (m_act) begin
            check("eng_rst", eng_rst, m_age == 1);
            check("eng_in", eng_in, m_text);
            check("eng_key", eng_key, m_key);
            if (m_age >= LAT + 3) begin
               check("rsp_data", rsp_data, aes_ref(m_text, m_key));
               check("rsp_id", rsp_id, m_own);
            end
         end
         if (eng_start) n_st++;
         if (eng_rst) n_rs++;
         for (int k = 0; k < N; k++) if (req_ready[k] && req_valid[k]) grants.push_back(k);
         if (!m_act && w >= 0) begin
            m_act = 1;
            m_age = 0;
            m_own = w;
            m_rr = w;
            m_text = req_text[128*w +: 128];
            m_key = req_key[128*w +: 128];
         end else if (m_act && m_age >= LAT + 3 && rsp_ready) begin
            m_act = 0;
            m_ops++;
         end
      end
   end

   task automatic set_req(input int i, input logic [127:0] t, input logic [127:0] k);
      @(posedge clk); #1;
      req_text[128*i +: 128] = t;
      req_key[128*i +: 128] = k;
      req_valid[i] = 1'b1;
   endtask

   task automatic wait_accept(input int i, output int h);
      bit done = 0;
      h = 0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge clk);
         if (req_ready[i] && req_valid[i]) begin
            done = 1;
            h = cyc;
         end
      end
      check("accept_seen", done, 1);
      @(posedge clk); #1;
      req_valid[i] = 1'b0;
   endtask

   task automatic wait_rsp(output int c);
      bit done = 0;
      c = 0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            done = 1;
            c = cyc;
         end
      end
      check("rsp_seen", done, 1);
   endtask

   task automatic pulse_rst();
      @(posedge clk); #1 rst = 1;
      @(negedge clk);
      @(posedge clk); #1 rst = 0;
   endtask

   initial begin
      int h, c;
      bit done;
      int exp3[5] = '{0, 1, 2, 3, 0};
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_eng_rst", eng_rst, 1);
      check("reset_rsp_valid", rsp_valid, 0);
      @(posedge clk); #1 rst = 0;
      // FIPS-197 vector on requester 0, with latency measurement
      set_req(0, T1, K1);
      wait_accept(0, h);
      wait_rsp(c);
      check("t1_latency", c - h, 44);
      check("t1_data", rsp_data, C1);
      check("t1_id", rsp_id, 0);
      // second known vector on requester 2
      set_req(2, T2, K2);
      wait_accept(2, h);
      wait_rsp(c);
      check("t2_data", rsp_data, C2);
      check("t2_id", rsp_id, 2);
      // all requesters continuously valid from a fresh reset
      pulse_rst();
      grants.delete();
      for (int i = 0; i < N; i++) begin
         req_text[128*i +: 128] = T3 ^ 128'(i + 1);
         req_key[128*i +: 128] = K3;
      end
      req_valid = '1;
      done = 0;
      for (int k = 0; k < 600 && !done; k++) begin
         @(negedge clk);
         done = ops_done == 16'd5;
      end
      check("t3_ops_done", ops_done, 5);
      check("t3_grant_count", grants.size() >= 5, 1);
      for (int i = 0; i < 5; i++) if (i < grants.size()) check($sformatf("t3_grant%0d", i), grants[i], exp3[i]);
      @(posedge clk); #1 req_valid = '0;
      done = 0;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clk);
         done = !busy;
      end
      check("t3_drain", done, 1);
      // consumer back-pressure for 20 cycles
      @(posedge clk); #1 rsp_ready = 0;
      set_req(1, T3, K3);
      wait_accept(1, h);
      wait_rsp(c);
      @(posedge clk); #1;
      req_text[127:0] = T1;
      req_key[127:0] = K1;
      req_valid[0] = 1'b1;
      repeat (20) begin
         @(negedge clk);
         check("t4_hold_valid", rsp_valid, 1);
         check("t4_hold_data", rsp_data, aes_ref(T3, K3));
         check("t4_hold_id", rsp_id, 1);
         check("t4_no_ready", req_ready, 0);
         check("t4_no_start", eng_start, 0);
      end
      @(posedge clk); #1 rsp_ready = 1;
      @(negedge clk);
      @(negedge clk);
      check("t4_idle", busy, 0);
      check("t4_next_grant", req_ready, 4'b0001);
      @(posedge clk); #1 req_valid[0] = 1'b0;
      wait_rsp(c);
      check("t4_next_data", rsp_data, C1);
      // reset in the middle of the latency wait, at counter value 20
      set_req(0, T2, K2);
      wait_accept(0, h);
      repeat (23) @(negedge clk);
      #2 rst = 1;
      #1;
      check("t5_eng_rst", eng_rst, 1);
      check("t5_rsp_valid", rsp_valid, 0);
      check("t5_ops_done", ops_done, 0);
      check("t5_busy", busy, 0);
      @(negedge clk);
      @(posedge clk); #1 rst = 0;
      set_req(0, T1, K1);
      wait_accept(0, h);
      wait_rsp(c);
      check("t5_data", rsp_data, C1);
      check("t5_id", rsp_id, 0);
      // rq1 served, then rq1 and rq3 contend: rq3 must win
      set_req(1, T3, K3);
      wait_accept(1, h);
      wait_rsp(c);
      @(posedge clk); #1;
      req_text[128*3 +: 128] = T2;
      req_key[128*3 +: 128] = K2;
      req_valid[1] = 1'b1;
      req_valid[3] = 1'b1;
      @(negedge clk);
      check("t6_grant", req_ready, 4'b1000);
      @(posedge clk); #1;
      req_valid[3] = 1'b0;
      n_st = 0;
      n_rs = 0;
      wait_rsp(c);
      check("t6_id", rsp_id, 3);
      check("t6_data", rsp_data, C2);
      check("t6_start_cycles", n_st, 1);
      check("t6_rst_cycles", n_rs, 1);
      wait_accept(1, h);
      wait_rsp(c);
      check("t6_second_id", rsp_id, 1);
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end
endmodule
